// File: rtl/mcu_pkg.sv
// Shared MCU definitions: bus master identifiers and the RAM byte-lane count.
package mcu_pkg;

  localparam int unsigned NUM_BE = 4;

  typedef enum logic {
    M0 = 1'b0,
    M1 = 1'b1
  } master_id_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant, registered last-grant state.
module rr_arb2
  import mcu_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  master_id_e last_grant;

  // On contention, the master not granted most recently wins.
  always_comb begin
    gnt = 2'b00;
    if (rst_n) begin
      if (req == 2'b11) gnt = (last_grant == M1) ? 2'b01 : 2'b10;
      else              gnt = req;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)      last_grant <= M1;
    else if (gnt[0]) last_grant <= M0;
    else if (gnt[1]) last_grant <= M1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one registered-output RAM between an instruction-fetch master (m0)
// and a load/store master (m1); one access per cycle, response one cycle later.
module ram_arbiter
  import mcu_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,

  input  logic                  m0_req_i,
  input  logic [ADDR_WIDTH-1:0] m0_addr_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,

  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [NUM_BE-1:0]     m1_be_i,
  input  logic [ADDR_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,

  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_din_o,
  output logic                  ram_we_o,
  output logic                  ram_be0_o,
  output logic                  ram_be1_o,
  output logic                  ram_be2_o,
  output logic                  ram_be3_o,
  input  logic [DATA_WIDTH-1:0] ram_dout_i
);

  logic [1:0]            gnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [NUM_BE-1:0]     be;
  logic                  resp_valid;
  master_id_e            resp_id;
  logic                  resp_we;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] read_data;

  rr_arb2 u_arb (
    .clk   (clk_i),
    .rst_n (rst_ni),
    .req   ({m1_req_i, m0_req_i}),
    .gnt   (gnt)
  );

  assign m0_gnt_o = gnt[0];
  assign m1_gnt_o = gnt[1];

  // The address keeps its last driven value on idle cycles.
  always_comb begin
    ram_addr_o = addr_q;
    ram_din_o  = '0;
    ram_we_o   = 1'b0;
    be         = '0;
    if (gnt[0]) begin
      ram_addr_o = m0_addr_i;
      be         = '1;
    end else if (gnt[1]) begin
      ram_addr_o = m1_addr_i;
      ram_din_o  = m1_wdata_i;
      ram_we_o   = m1_we_i;
      be         = m1_be_i;
    end
    if (!rst_ni) ram_addr_o = '0;
  end

  assign ram_be0_o = be[0];
  assign ram_be1_o = be[1];
  assign ram_be2_o = be[2];
  assign ram_be3_o = be[3];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      addr_q     <= '0;
      resp_valid <= 1'b0;
      resp_id    <= M0;
      resp_we    <= 1'b0;
    end else begin
      if (|gnt) addr_q <= ram_addr_o;
      resp_valid <= |gnt;
      resp_id    <= gnt[1] ? M1 : M0;
      resp_we    <= gnt[1] & m1_we_i;
    end
  end

  // Gating with rst_ni drops a response whose grant is followed by reset.
  assign rvalid      = resp_valid & rst_ni;
  assign read_data   = (rvalid && !resp_we) ? ram_dout_i : '0;
  assign m0_rvalid_o = rvalid && (resp_id == M0);
  assign m1_rvalid_o = rvalid && (resp_id == M1);
  assign m0_rdata_o  = m0_rvalid_o ? read_data : '0;
  assign m1_rdata_o  = m1_rvalid_o ? read_data : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural byte-enabled RAM.
module tb_ram_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        m0_req_i;
  logic [11:0] m0_addr_i;
  logic        m0_gnt_o, m0_rvalid_o;
  logic [31:0] m0_rdata_o;
  logic        m1_req_i, m1_we_i;
  logic [3:0]  m1_be_i;
  logic [11:0] m1_addr_i;
  logic [31:0] m1_wdata_i;
  logic        m1_gnt_o, m1_rvalid_o;
  logic [31:0] m1_rdata_o;
  logic [11:0] ram_addr_o;
  logic [31:0] ram_din_o;
  logic        ram_we_o, ram_be0_o, ram_be1_o, ram_be2_o, ram_be3_o;
  logic [31:0] ram_dout_i;

  logic [31:0] mem [0:4095];
  int n_cmp = 0;
  int n_err = 0;

  always #5 clk_i = ~clk_i;

  ram_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .m0_req_i(m0_req_i), .m0_addr_i(m0_addr_i), .m0_gnt_o(m0_gnt_o),
    .m0_rvalid_o(m0_rvalid_o), .m0_rdata_o(m0_rdata_o),
    .m1_req_i(m1_req_i), .m1_we_i(m1_we_i), .m1_be_i(m1_be_i),
    .m1_addr_i(m1_addr_i), .m1_wdata_i(m1_wdata_i), .m1_gnt_o(m1_gnt_o),
    .m1_rvalid_o(m1_rvalid_o), .m1_rdata_o(m1_rdata_o),
    .ram_addr_o(ram_addr_o), .ram_din_o(ram_din_o), .ram_we_o(ram_we_o),
    .ram_be0_o(ram_be0_o), .ram_be1_o(ram_be1_o), .ram_be2_o(ram_be2_o),
    .ram_be3_o(ram_be3_o), .ram_dout_i(ram_dout_i)
  );

  // Registered RAM: read data appears the cycle after the address.
  always @(posedge clk_i) begin
    if (ram_we_o) begin
      if (ram_be0_o) mem[ram_addr_o][7:0]   <= ram_din_o[7:0];
      if (ram_be1_o) mem[ram_addr_o][15:8]  <= ram_din_o[15:8];
      if (ram_be2_o) mem[ram_addr_o][23:16] <= ram_din_o[23:16];
      if (ram_be3_o) mem[ram_addr_o][31:24] <= ram_din_o[31:24];
    end
    ram_dout_i <= mem[ram_addr_o];
  end

  task automatic drive_idle();
    m0_req_i = 1'b0; m0_addr_i = '0;
    m1_req_i = 1'b0; m1_we_i = 1'b0; m1_be_i = '0; m1_addr_i = '0; m1_wdata_i = '0;
  endtask

  // Advance one cycle; inputs change and outputs are sampled mid-cycle.
  task automatic next_cycle();
    @(posedge clk_i);
    #4;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_idle();
    m0_req_i = 1'b1; m1_req_i = 1'b1; m1_we_i = 1'b1; m1_be_i = 4'hF; m0_addr_i = 12'h3FF;
    next_cycle();
    next_cycle();
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o} !== 2'b00) begin
      n_err++; $display("FAIL reset_gnt: got %b want 00", {m0_gnt_o, m1_gnt_o});
    end
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o, ram_we_o, ram_be0_o, ram_be1_o, ram_be2_o, ram_be3_o} !== 7'b0) begin
      n_err++; $display("FAIL reset_ctrl: got %b want 0000000",
        {m0_rvalid_o, m1_rvalid_o, ram_we_o, ram_be0_o, ram_be1_o, ram_be2_o, ram_be3_o});
    end
    n_cmp++;
    if (ram_addr_o !== 12'h000) begin
      n_err++; $display("FAIL reset_addr: got %h want 000", ram_addr_o);
    end
    drive_idle();
    next_cycle();
    rst_ni = 1'b1;
  endtask

  task automatic test_contention();
    logic [1:0] exp_g [4];
    logic [1:0] prev;
    exp_g[0] = 2'b01; exp_g[1] = 2'b10; exp_g[2] = 2'b01; exp_g[3] = 2'b10;
    prev = 2'b00;
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        m0_req_i = 1'b1; m0_addr_i = 12'h100;
        m1_req_i = 1'b1; m1_addr_i = 12'h200; m1_we_i = 1'b0; m1_be_i = 4'hF;
      end else begin
        drive_idle();
      end
      #1;
      n_cmp++;
      if ({m1_gnt_o, m0_gnt_o} !== ((i < 4) ? exp_g[i] : 2'b00)) begin
        n_err++; $display("FAIL contention_gnt[%0d]: got %b want %b", i, {m1_gnt_o, m0_gnt_o},
          (i < 4) ? exp_g[i] : 2'b00);
      end
      n_cmp++;
      if ({m1_rvalid_o, m0_rvalid_o} !== prev) begin
        n_err++; $display("FAIL contention_rvalid[%0d]: got %b want %b", i, {m1_rvalid_o, m0_rvalid_o}, prev);
      end
      prev = (i < 4) ? exp_g[i] : 2'b00;
      next_cycle();
    end
  endtask

  task automatic test_m0_read();
    mem[12'h010] = 32'hDEADBEEF;
    m0_req_i = 1'b1; m0_addr_i = 12'h010;
    #1;
    n_cmp++;
    if ({m0_gnt_o, m1_gnt_o, ram_addr_o, ram_we_o, ram_be3_o, ram_be2_o, ram_be1_o, ram_be0_o, ram_din_o}
        !== {2'b10, 12'h010, 1'b0, 4'hF, 32'h0}) begin
      n_err++; $display("FAIL m0_read_req: gnt=%b%b addr=%h we=%b be=%b%b%b%b din=%h",
        m0_gnt_o, m1_gnt_o, ram_addr_o, ram_we_o, ram_be3_o, ram_be2_o, ram_be1_o, ram_be0_o, ram_din_o);
    end
    next_cycle();
    drive_idle();
    #1;
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o} !== {2'b10, 32'hDEADBEEF}) begin
      n_err++; $display("FAIL m0_read_resp: rvalid=%b%b rdata=%h want 10 deadbeef",
        m0_rvalid_o, m1_rvalid_o, m0_rdata_o);
    end
    next_cycle();
  endtask

  task automatic test_write_be();
    mem[12'h020] = 32'hAABBCCDD;
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_be_i = 4'b0011; m1_addr_i = 12'h020; m1_wdata_i = 32'h12345678;
    #1;
    n_cmp++;
    if ({m1_gnt_o, ram_we_o, ram_be3_o, ram_be2_o, ram_be1_o, ram_be0_o, ram_din_o}
        !== {1'b1, 1'b1, 4'b0011, 32'h12345678}) begin
      n_err++; $display("FAIL write_req: gnt=%b we=%b be=%b%b%b%b din=%h",
        m1_gnt_o, ram_we_o, ram_be3_o, ram_be2_o, ram_be1_o, ram_be0_o, ram_din_o);
    end
    next_cycle();
    m1_we_i = 1'b0; m1_be_i = 4'hF; m1_wdata_i = 32'hFFFFFFFF;
    #1;
    n_cmp++;
    if ({m1_rvalid_o, m1_rdata_o, m1_gnt_o, ram_we_o} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
      n_err++; $display("FAIL write_ack: rvalid=%b rdata=%h gnt=%b we=%b", m1_rvalid_o, m1_rdata_o, m1_gnt_o, ram_we_o);
    end
    next_cycle();
    drive_idle();
    #1;
    n_cmp++;
    if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, 32'hAABB5678}) begin
      n_err++; $display("FAIL write_readback: rvalid=%b rdata=%h want 1 aabb5678", m1_rvalid_o, m1_rdata_o);
    end
    next_cycle();
  endtask

  task automatic test_be_zero();
    mem[12'h030] = 32'hCAFEF00D;
    m1_req_i = 1'b1; m1_we_i = 1'b1; m1_be_i = 4'b0000; m1_addr_i = 12'h030; m1_wdata_i = 32'h0;
    #1;
    n_cmp++;
    if ({m1_gnt_o, ram_we_o, ram_be3_o, ram_be2_o, ram_be1_o, ram_be0_o} !== 6'b110000) begin
      n_err++; $display("FAIL be0_req: gnt=%b we=%b be=%b%b%b%b want 1 1 0000",
        m1_gnt_o, ram_we_o, ram_be3_o, ram_be2_o, ram_be1_o, ram_be0_o);
    end
    next_cycle();
    m1_we_i = 1'b0; m1_be_i = 4'hF;
    #1;
    n_cmp++;
    if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, 32'h0}) begin
      n_err++; $display("FAIL be0_ack: rvalid=%b rdata=%h want 1 0", m1_rvalid_o, m1_rdata_o);
    end
    next_cycle();
    drive_idle();
    #1;
    n_cmp++;
    if ({m1_rvalid_o, m1_rdata_o} !== {1'b1, 32'hCAFEF00D}) begin
      n_err++; $display("FAIL be0_readback: rvalid=%b rdata=%h want 1 cafef00d", m1_rvalid_o, m1_rdata_o);
    end
    next_cycle();
  endtask

  task automatic test_idle();
    m0_req_i = 1'b1; m0_addr_i = 12'h055;
    next_cycle();
    drive_idle();
    next_cycle();
    #1;
    n_cmp++;
    if ({ram_we_o, ram_be0_o, ram_be1_o, ram_be2_o, ram_be3_o, m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m1_gnt_o}
        !== 9'b0) begin
      n_err++; $display("FAIL idle_ctrl: we=%b be=%b%b%b%b rvalid=%b%b gnt=%b%b",
        ram_we_o, ram_be3_o, ram_be2_o, ram_be1_o, ram_be0_o, m0_rvalid_o, m1_rvalid_o, m0_gnt_o, m1_gnt_o);
    end
    n_cmp++;
    if (ram_addr_o !== 12'h055) begin
      n_err++; $display("FAIL idle_addr: got %h want 055", ram_addr_o);
    end
    next_cycle();
  endtask

  task automatic test_reset_after_grant();
    m0_req_i = 1'b1; m0_addr_i = 12'h010;
    #1;
    n_cmp++;
    if (m0_gnt_o !== 1'b1) begin
      n_err++; $display("FAIL rst_grant: got %b want 1", m0_gnt_o);
    end
    next_cycle();
    drive_idle();
    rst_ni = 1'b0;
    #1;
    n_cmp++;
    if ({m0_rvalid_o, m1_rvalid_o, m0_rdata_o, ram_we_o, ram_addr_o, m0_gnt_o, m1_gnt_o} !== '0) begin
      n_err++; $display("FAIL rst_suppress: rvalid=%b%b rdata=%h we=%b addr=%h gnt=%b%b",
        m0_rvalid_o, m1_rvalid_o, m0_rdata_o, ram_we_o, ram_addr_o, m0_gnt_o, m1_gnt_o);
    end
    next_cycle();
    rst_ni = 1'b1;
    m0_req_i = 1'b1; m0_addr_i = 12'h011;
    m1_req_i = 1'b1; m1_addr_i = 12'h021;
    #1;
    n_cmp++;
    if ({m1_gnt_o, m0_gnt_o} !== 2'b01) begin
      n_err++; $display("FAIL rst_first_contention: got %b want 01", {m1_gnt_o, m0_gnt_o});
    end
    next_cycle();
    drive_idle();
    next_cycle();
  endtask

  initial begin
    drive_idle();
    rst_ni = 1'b0;
    #1;
    test_reset();
    test_contention();
    test_m0_read();
    test_write_be();
    test_be_zero();
    test_idle();
    test_reset_after_grant();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
